// File: rtl/demux13x32_reg_pkg.sv
// Shared types for the registered 1-to-3 word demultiplexer: select codes,
// slot states and default widths.
package demux_pkg;
  localparam int unsigned DEMUX_W  = 32;
  localparam int unsigned DEMUX_CW = 16;

  typedef enum logic [1:0] {
    SEL_A   = 2'b00,
    SEL_B   = 2'b01,
    SEL_C   = 2'b10,
    SEL_BAD = 2'b11
  } sel_e;

  typedef enum logic {
    SLOT_EMPTY = 1'b0,
    SLOT_FULL  = 1'b1
  } slot_e;
endpackage

// File: rtl/demux13x32_reg_if.sv
// Input stream and three output channels of demux13x32_reg.
// Counter signals exist only when DEMUX_CNT_EN is defined.
interface demux13x32_reg_if #(
  parameter int unsigned W  = demux_pkg::DEMUX_W
`ifdef DEMUX_CNT_EN
 ,parameter int unsigned CW = demux_pkg::DEMUX_CW
`endif
);
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_data;
  logic [1:0]   in_sel;
  logic         a_valid, b_valid, c_valid;
  logic         a_ready, b_ready, c_ready;
  logic [W-1:0] a_data, b_data, c_data;
  logic         err;
`ifdef DEMUX_CNT_EN
  logic [CW-1:0] a_cnt, b_cnt, c_cnt;
`endif

  modport master (
    output in_valid, in_data, in_sel, a_ready, b_ready, c_ready,
    input  in_ready, a_valid, b_valid, c_valid, a_data, b_data, c_data, err
`ifdef DEMUX_CNT_EN
   ,input  a_cnt, b_cnt, c_cnt
`endif
  );

  modport slave (
    input  in_valid, in_data, in_sel, a_ready, b_ready, c_ready,
    output in_ready, a_valid, b_valid, c_valid, a_data, b_data, c_data, err
`ifdef DEMUX_CNT_EN
   ,output a_cnt, b_cnt, c_cnt
`endif
  );
endinterface

// File: rtl/demux13x32_reg_slot.sv
// One-entry output holding register with valid/ready drain.
// Optional drain counter guarded by DEMUX_CNT_EN.
module demux_slot
  import demux_pkg::*;
#(
  parameter int unsigned W  = DEMUX_W
`ifdef DEMUX_CNT_EN
 ,parameter int unsigned CW = DEMUX_CW
`endif
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          wr_en,
  input  logic [W-1:0]  wr_data,
  output logic          valid,
  input  logic          ready,
  output logic [W-1:0]  data
`ifdef DEMUX_CNT_EN
 ,output logic [CW-1:0] cnt
`endif
);
  slot_e        r_state;
  slot_e        w_state_nxt;
  logic [W-1:0] r_data;
  logic         w_drain;

  assign w_drain = (r_state == SLOT_FULL) && ready;

  // A write wins over a drain, so drain+write keeps the slot full.
  always_comb begin
    w_state_nxt = r_state;
    if (wr_en)
      w_state_nxt = SLOT_FULL;
    else if (w_drain)
      w_state_nxt = SLOT_EMPTY;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= SLOT_EMPTY;
      r_data  <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (wr_en)
        r_data <= wr_data;
    end
  end

  assign valid = (r_state == SLOT_FULL);
  assign data  = r_data;

`ifdef DEMUX_CNT_EN
  logic [CW-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (reset)
      r_cnt <= '0;
    else if (w_drain)
      r_cnt <= r_cnt + 1'b1;
  end

  assign cnt = r_cnt;
`endif
endmodule

// File: rtl/demux13x32_reg.sv
// Registered 1-to-3 word demultiplexer: select decode, in_ready mux, sticky err.
// Optional per-channel drain counters with DEMUX_CNT_EN.
module demux13x32_reg
  import demux_pkg::*;
#(
  parameter int unsigned W  = DEMUX_W
`ifdef DEMUX_CNT_EN
 ,parameter int unsigned CW = DEMUX_CW
`endif
) (
  input logic             clk,
  input logic             reset,
  demux13x32_reg_if.slave bus
);
  sel_e       w_sel;
  logic       w_in_ready;
  logic       w_accept;
  logic [2:0] w_wr_en;
  logic       r_err;

  assign w_sel = sel_e'(bus.in_sel);

  always_comb begin
    w_in_ready = 1'b0;
    if (!reset) begin
      case (w_sel)
        SEL_A:   w_in_ready = !bus.a_valid || bus.a_ready;
        SEL_B:   w_in_ready = !bus.b_valid || bus.b_ready;
        SEL_C:   w_in_ready = !bus.c_valid || bus.c_ready;
        default: w_in_ready = 1'b1;
      endcase
    end
  end

  assign bus.in_ready = w_in_ready;
  assign w_accept     = bus.in_valid && w_in_ready;
  assign w_wr_en      = {w_accept && (w_sel == SEL_C),
                         w_accept && (w_sel == SEL_B),
                         w_accept && (w_sel == SEL_A)};

  always_ff @(posedge clk) begin
    if (reset)
      r_err <= 1'b0;
    else if (w_accept && (w_sel == SEL_BAD))
      r_err <= 1'b1;
  end

  assign bus.err = r_err;

  demux_slot #(
    .W (W)
`ifdef DEMUX_CNT_EN
   ,.CW(CW)
`endif
  ) u_slot_a (
    .clk    (clk),
    .reset  (reset),
    .wr_en  (w_wr_en[0]),
    .wr_data(bus.in_data),
    .valid  (bus.a_valid),
    .ready  (bus.a_ready),
    .data   (bus.a_data)
`ifdef DEMUX_CNT_EN
   ,.cnt    (bus.a_cnt)
`endif
  );

  demux_slot #(
    .W (W)
`ifdef DEMUX_CNT_EN
   ,.CW(CW)
`endif
  ) u_slot_b (
    .clk    (clk),
    .reset  (reset),
    .wr_en  (w_wr_en[1]),
    .wr_data(bus.in_data),
    .valid  (bus.b_valid),
    .ready  (bus.b_ready),
    .data   (bus.b_data)
`ifdef DEMUX_CNT_EN
   ,.cnt    (bus.b_cnt)
`endif
  );

  demux_slot #(
    .W (W)
`ifdef DEMUX_CNT_EN
   ,.CW(CW)
`endif
  ) u_slot_c (
    .clk    (clk),
    .reset  (reset),
    .wr_en  (w_wr_en[2]),
    .wr_data(bus.in_data),
    .valid  (bus.c_valid),
    .ready  (bus.c_ready),
    .data   (bus.c_data)
`ifdef DEMUX_CNT_EN
   ,.cnt    (bus.c_cnt)
`endif
  );
endmodule

// File: tb/tb_demux13x32_reg.sv
// Bench for demux13x32_reg: directed scenarios plus random traffic against a
// slot-occupancy model; counters are checked when DEMUX_CNT_EN is defined.
module tb_demux13x32_reg;
  localparam int W = 32;
`ifdef DEMUX_CNT_EN
  localparam int CW = 4;
`endif

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  demux13x32_reg_if #(
    .W (W)
`ifdef DEMUX_CNT_EN
   ,.CW(CW)
`endif
  ) bus ();

  demux13x32_reg #(
    .W (W)
`ifdef DEMUX_CNT_EN
   ,.CW(CW)
`endif
  ) u_dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  int unsigned checks = 0;
  int unsigned errors = 0;

  bit           m_full [3];
  logic [W-1:0] m_word [3];
  bit           m_err;
  int unsigned  m_cnt  [3];
  bit           started = 1'b0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic inp_ready(input int c);
    case (c)
      0: return bus.a_ready;
      1: return bus.b_ready;
      default: return bus.c_ready;
    endcase
  endfunction

  function automatic logic dut_valid(input int c);
    case (c)
      0: return bus.a_valid;
      1: return bus.b_valid;
      default: return bus.c_valid;
    endcase
  endfunction

  function automatic logic [W-1:0] dut_data(input int c);
    case (c)
      0: return bus.a_data;
      1: return bus.b_data;
      default: return bus.c_data;
    endcase
  endfunction

`ifdef DEMUX_CNT_EN
  function automatic logic [CW-1:0] dut_cnt(input int c);
    case (c)
      0: return bus.a_cnt;
      1: return bus.b_cnt;
      default: return bus.c_cnt;
    endcase
  endfunction
`endif

  // Illegal select always accepts; legal select accepts if target empty or draining.
  function automatic logic model_in_ready();
    if (reset) return 1'b0;
    if (bus.in_sel == 2'd3) return 1'b1;
    return !m_full[bus.in_sel] || inp_ready(int'(bus.in_sel));
  endfunction

  always @(posedge clk) begin : model_upd
    logic acc;
    int   s;
    started = 1'b1;
    if (reset) begin
      for (int c = 0; c < 3; c++) begin
        m_full[c] = 1'b0; m_word[c] = '0; m_cnt[c] = 0;
      end
      m_err = 1'b0;
    end else begin
      acc = bus.in_valid && model_in_ready();
      s   = int'(bus.in_sel);
      for (int c = 0; c < 3; c++)
        if (m_full[c] && inp_ready(c)) begin
          m_full[c] = 1'b0;
`ifdef DEMUX_CNT_EN
          m_cnt[c] = (m_cnt[c] + 1) % (1 << CW);
`else
          m_cnt[c] = m_cnt[c] + 1;
`endif
        end
      if (acc) begin
        if (s == 3) m_err = 1'b1;
        else begin
          m_full[s] = 1'b1;
          m_word[s] = bus.in_data;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (started) begin
      chk("in_ready", 64'(bus.in_ready), 64'(model_in_ready()));
      chk("err", 64'(bus.err), 64'(m_err));
      for (int c = 0; c < 3; c++) begin
        chk($sformatf("valid[%0d]", c), 64'(dut_valid(c)), 64'(m_full[c]));
        if (m_full[c])
          chk($sformatf("data[%0d]", c), 64'(dut_data(c)), 64'(m_word[c]));
`ifdef DEMUX_CNT_EN
        chk($sformatf("cnt[%0d]", c), 64'(dut_cnt(c)), 64'(m_cnt[c]));
`endif
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1;
    bus.in_valid = 1'b1; bus.in_sel = 2'd0; bus.in_data = 32'hAAAA_5555;
    bus.a_ready = 1'b0; bus.b_ready = 1'b0; bus.c_ready = 1'b0;
    tick(); tick();
    #1;
    chk("rst_a_valid", 64'(bus.a_valid), 0);
    chk("rst_b_valid", 64'(bus.b_valid), 0);
    chk("rst_c_valid", 64'(bus.c_valid), 0);
    chk("rst_a_data", 64'(bus.a_data), 0);
    chk("rst_b_data", 64'(bus.b_data), 0);
    chk("rst_c_data", 64'(bus.c_data), 0);
    chk("rst_err", 64'(bus.err), 0);
    chk("rst_in_ready", 64'(bus.in_ready), 0);

    reset = 1'b0; bus.in_sel = 2'd0; bus.in_data = 32'h0000_0001;
    tick();
    bus.in_valid = 1'b0;
    #1;
    chk("first_a_valid", 64'(bus.a_valid), 1);
    chk("first_a_data", 64'(bus.a_data), 64'h1);
    chk("first_b_valid", 64'(bus.b_valid), 0);
    chk("first_c_valid", 64'(bus.c_valid), 0);

    bus.in_valid = 1'b1; bus.in_sel = 2'd1; bus.in_data = 32'hDEAD_BEEF;
    tick();
    bus.in_data = 32'h1234_5678;
    #1;
    chk("bp_in_ready", 64'(bus.in_ready), 0);
    chk("bp_b_data", 64'(bus.b_data), 64'hDEAD_BEEF);
    tick(); #1;
    chk("bp_hold_b_data", 64'(bus.b_data), 64'hDEAD_BEEF);
    chk("bp_hold_in_ready", 64'(bus.in_ready), 0);
    bus.b_ready = 1'b1;
    #1;
    chk("bp_release_rdy", 64'(bus.in_ready), 1);
    tick();
    bus.in_valid = 1'b0;
    #1;
    chk("bp_b_data2", 64'(bus.b_data), 64'h1234_5678);
    chk("bp_b_valid2", 64'(bus.b_valid), 1);
    tick(); #1;
    chk("bp_b_drained", 64'(bus.b_valid), 0);

    bus.in_valid = 1'b1; bus.in_sel = 2'd2; bus.in_data = 32'hCAFE_0000;
    #1;
    chk("ind_in_ready", 64'(bus.in_ready), 1);
    tick();
    bus.in_valid = 1'b0;
    #1;
    chk("ind_c_data", 64'(bus.c_data), 64'hCAFE_0000);
    chk("ind_a_valid", 64'(bus.a_valid), 1);
    chk("ind_a_data", 64'(bus.a_data), 64'h1);

    bus.a_ready = 1'b1; bus.b_ready = 1'b1; bus.c_ready = 1'b1;
    for (int i = 0; i < 30; i++) begin
      bus.in_valid = 1'b1;
      bus.in_sel   = 2'(i % 3);
      bus.in_data  = 32'h5000_0000 + 32'(i);
      #1;
      chk("stream_rdy", 64'(bus.in_ready), 1);
      tick(); #1;
      chk("stream_valid", 64'(dut_valid(i % 3)), 1);
      chk("stream_data", 64'(dut_data(i % 3)), 64'(32'h5000_0000 + 32'(i)));
    end
    bus.in_valid = 1'b0;
    tick();

    bus.in_valid = 1'b1; bus.in_sel = 2'd3; bus.in_data = 32'hFFFF_FFFF;
    #1;
    chk("bad_in_ready", 64'(bus.in_ready), 1);
    tick();
    bus.in_valid = 1'b0;
    #1;
    chk("bad_err", 64'(bus.err), 1);
    chk("bad_a_valid", 64'(bus.a_valid), 0);
    chk("bad_b_valid", 64'(bus.b_valid), 0);
    chk("bad_c_valid", 64'(bus.c_valid), 0);
    repeat (3) tick();
    #1;
    chk("bad_err_sticky", 64'(bus.err), 1);

    reset = 1'b1;
    tick();
    reset = 1'b0;
    #1;
    chk("err_cleared", 64'(bus.err), 0);

`ifdef DEMUX_CNT_EN
    bus.in_valid = 1'b1; bus.in_sel = 2'd2;
    for (int i = 0; i < 17; i++) begin
      bus.in_data = 32'(i);
      tick();
    end
    bus.in_valid = 1'b0;
    tick(); tick(); #1;
    chk("cnt_c_wrap", 64'(bus.c_cnt), 1);
    chk("cnt_a_zero", 64'(bus.a_cnt), 0);
    chk("cnt_b_zero", 64'(bus.b_cnt), 0);
`endif

    repeat (3000) begin
      reset        = ($urandom_range(0, 99) == 0);
      bus.in_valid = ($urandom_range(0, 3) != 0);
      bus.in_sel   = ($urandom_range(0, 15) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
      bus.in_data  = $urandom;
      bus.a_ready  = ($urandom_range(0, 3) != 0);
      bus.b_ready  = ($urandom_range(0, 2) != 0);
      bus.c_ready  = ($urandom_range(0, 4) != 0);
      tick();
    end
    reset = 1'b0;
    bus.in_valid = 1'b0;
    tick(); tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/demux13x32_reg.md
Name: demux13x32_reg

Overview:
- Registered 1-to-3 word demultiplexer.
- Steers one 32-bit input stream to one of three output channels, a, b or c, using a 2-bit select.
- Each output has a one-entry holding register and a valid/ready handshake.
- Sits after the datapath result bus and distributes results back to the three operand destinations that the 3:1 operand mux selects from.

Parameters:
- W, 32, data width of input and each output.
- CW, 16, width of per-channel transfer counters (used only with DEMUX_CNT_EN).

Ports:
- clk  input  1  rising-edge clock, single clock domain
- reset  input  1  synchronous, active-high reset
- in_valid  input  1  input word present
- in_ready  output  1  input word accepted this cycle when in_valid && in_ready
- in_data  input  W  input word
- in_sel  input  2  destination: 00=a, 01=b, 10=c, 11=illegal
- a_valid, b_valid, c_valid  output  1 each  channel holds a word
- a_ready, b_ready, c_ready  input  1 each  consumer takes word this cycle
- a_data, b_data, c_data  output  W each  channel word
- err  output  1  sticky flag: an illegal select (11) was accepted
- a_cnt, b_cnt, c_cnt  output  CW each  transfer counters (present only with DEMUX_CNT_EN)

Behaviour:
- Reset is synchronous, active-high, one clock and single clock domain. While reset is high at a clk edge:
  - all x_valid go to 0, all x_data go to 0, err goes to 0, counters go to 0;
  - pending words are discarded;
  - in_ready is forced to 0 during reset.
- Each channel has one slot with state EMPTY (x_valid=0) or FULL (x_valid=1).
- in_ready is combinational on in_sel, the target slot state and the target x_ready:
  - in_sel=00/01/10: in_ready = !x_valid || x_ready, for the selected x.
  - in_sel=11: in_ready = 1. The word is consumed and discarded, and err is set to 1 at the next edge (sticky until reset).
- Accept (in_valid && in_ready, legal select): in_data is written to the selected slot and x_valid=1 on the next edge. Latency is exactly 1 cycle.
- Drain (x_valid && x_ready, no new write to x): x_valid=0 on the next edge.
- Simultaneous drain and write on the same channel: the slot stays FULL with the new data, giving back-to-back throughput of 1 word/cycle per channel.
- While x_valid && !x_ready: x_data and x_valid hold stable. A write to another channel proceeds independently.
- Full throughput: 1 word/cycle total across channels when the consumers are ready.
- Non-selected channels are never modified by an input transfer.
- in_sel and in_data are sampled only on an accepted transfer; their values when in_valid=0 are ignored.
- No combinational path from in_data to any x_data; all outputs except in_ready are registered.

Optional Feature:
- Macro DEMUX_CNT_EN.
- Defined: ports a_cnt, b_cnt and c_cnt exist.
  - Each counter increments by 1 on every drain handshake of its channel (x_valid && x_ready).
  - Counters wrap modulo 2^CW.
  - Counters reset to 0.
- Undefined: the counter ports and logic are absent; all other behaviour is identical.

Decomposition:
- Package demux_pkg:
  - select encodings SEL_A=2'b00, SEL_B=2'b01, SEL_C=2'b10, SEL_BAD=2'b11;
  - default W=32.
- Sub-module demux_slot: one-entry register with ports clk, reset, wr_en, wr_data, valid, ready, data, and with the optional counter. It is instantiated three times. The top level holds the select decode, the in_ready mux and the err flag.

Test Plan:
- Reset: assert reset 2 cycles while in_valid=1 -> all x_valid=0, x_data=0, err=0, in_ready=0. After release, first accept sel=00 data=32'h0000_0001 -> a_valid=1, a_data=32'h1 one cycle later; b and c untouched.
- Backpressure: b_ready=0, send sel=01 32'hDEAD_BEEF then sel=01 32'h1234_5678 -> second word stalls (in_ready=0) and b_data holds DEAD_BEEF. Raise b_ready -> next cycle b_data=1234_5678, no word lost.
- Streaming: all ready=1, send 30 words rotating sel 00,01,10 -> one accept per cycle, each channel receives its 10 words in order with 1-cycle latency.
- Independence: a_ready=0 with a full, send sel=10 32'hCAFE_0000 -> accepted immediately, c_data=CAFE_0000 next cycle, a unchanged.
- Illegal select: send sel=11 32'hFFFF_FFFF -> in_ready=1, no channel valid, err=1 and stays 1 until reset.
- Counters (DEMUX_CNT_EN, CW=4): drain 17 words on channel c -> c_cnt=1 (wrapped); a_cnt and b_cnt stay 0.
